// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI byte parser producing note_on/note_off pulses, tone period and held state
module midi_note_decoder #(
   parameter int CHANNEL = 0,
   parameter bit OMNI    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        note_on,
   output logic        note_off,
   output logic [22:0] period,
   output logic [6:0]  note,
   output logic [6:0]  velocity,
   output logic        held
);
   typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;
   localparam logic [19:0] BASE [12] = '{
      20'd587099, 20'd554147, 20'd523045, 20'd493689, 20'd465980, 20'd439827,
      20'd415141, 20'd391841, 20'd369849, 20'd349091, 20'd329498, 20'd311005
   };
   state_t      state;
   logic [7:0]  status;
   logic [6:0]  d1;
   logic        s1_v, s1_on;
   logic [6:0]  s1_key, s1_vel;
   logic [19:0] s1_base;
   logic [3:0]  s1_oct;
   logic        is_data, one_byte, done, ev;
   assign is_data  = rx_valid && !rx_data[7];
   assign one_byte = status[7:5] == 3'b110;
   assign done     = is_data && (state == DATA2 || (state == DATA1 && one_byte));
   assign ev       = done && status[7:5] == 3'b100 && (OMNI || status[3:0] == 4'(CHANNEL));
   // Parser: track running status and collect data bytes; real-time bytes leave everything untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         status <= 8'd0;
         d1     <= 7'd0;
      end else if (rx_valid && rx_data[7]) begin
         if (rx_data[7:4] != 4'hF) begin
            status <= rx_data;
            state  <= DATA1;
         end else if (!rx_data[3]) begin
            status <= 8'd0;
            state  <= IDLE;
         end
      end else if (is_data) begin
         if (state == DATA1 && !one_byte) begin
            d1    <= rx_data[6:0];
            state <= DATA2;
         end else if (state == DATA2) begin
            state <= DATA1;
         end
      end
   end
   // Table stage: look up the octave -1 period and split the key into octave for the shifter
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_on   <= 1'b0;
         s1_key  <= 7'd0;
         s1_vel  <= 7'd0;
         s1_base <= 20'd0;
         s1_oct  <= 4'd0;
      end else begin
         s1_v    <= ev;
         s1_on   <= status[4] && rx_data[6:0] != 7'd0;
         s1_key  <= d1;
         s1_vel  <= rx_data[6:0];
         s1_base <= BASE[4'(d1 % 7'd12)];
         s1_oct  <= 4'(d1 / 7'd12);
      end
   end
   // Shift stage: apply note-on (always) or note-off (only for the held key) to the output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         note_on  <= 1'b0;
         note_off <= 1'b0;
         period   <= 23'd0;
         note     <= 7'd0;
         velocity <= 7'd0;
         held     <= 1'b0;
      end else begin
         note_on  <= 1'b0;
         note_off <= 1'b0;
         if (s1_v && s1_on) begin
            note_on  <= 1'b1;
            note     <= s1_key;
            velocity <= s1_vel;
            period   <= 23'(s1_base >> s1_oct);
            held     <= 1'b1;
         end else if (s1_v && held && s1_key == note) begin
            note_off <= 1'b1;
            held     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: directed and random byte streams checked against a message-level model
module tb_midi_note_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        note_on, note_off, held;
   logic [22:0] period;
   logic [6:0]  note, velocity;

   midi_note_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .note_on(note_on), .note_off(note_off), .period(period),
      .note(note), .velocity(velocity), .held(held)
   );

   always #5 clk = ~clk;

   typedef struct {int due; bit on; bit [6:0] key; bit [6:0] vel;} ev_t;
   ev_t      evq[$];
   bit [6:0] m_data[$];
   bit [7:0] m_status;
   int       base_tab[12];
   int       cyc = 0;
   int       checks = 0, errs = 0;
   bit       chk_en = 1'b0;
   bit       exp_on, exp_off, exp_held;
   bit [6:0] exp_note, exp_vel;
   int       exp_per;

   function automatic int per_of(input int key);
      return base_tab[key % 12] >> (key / 12);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Reference model: whole messages in, events out one edge after the final byte is sampled
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         cyc++;
         exp_on  = 1'b0;
         exp_off = 1'b0;
         if (rst) begin
            evq.delete();
            m_data.delete();
            m_status = 8'd0;
            exp_held = 1'b0;
            exp_note = 7'd0;
            exp_vel  = 7'd0;
            exp_per  = 0;
         end else begin
            while (evq.size() > 0 && evq[0].due == cyc) begin
               e = evq.pop_front();
               if (e.on) begin
                  exp_on   = 1'b1;
                  exp_note = e.key;
                  exp_vel  = e.vel;
                  exp_per  = per_of(int'(e.key));
                  exp_held = 1'b1;
               end else if (exp_held && e.key == exp_note) begin
                  exp_off  = 1'b1;
                  exp_held = 1'b0;
               end
            end
            if (rx_valid) begin
               if (rx_data >= 8'hF8) begin
               end else if (rx_data >= 8'hF0) begin
                  m_status = 8'd0;
                  m_data.delete();
               end else if (rx_data[7]) begin
                  m_status = rx_data;
                  m_data.delete();
               end else if (m_status != 8'd0) begin
                  m_data.push_back(rx_data[6:0]);
                  if (m_data.size() == ((m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2)) begin
                     if ((m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9) && m_status[3:0] == 4'd0) begin
                        e.due = cyc + 1;
                        e.on  = m_status[7:4] == 4'h9 && m_data[1] != 7'd0;
                        e.key = m_data[0];
                        e.vel = m_data[1];
                        evq.push_back(e);
                     end
                     m_data.delete();
                  end
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            checks++;
            if (note_on !== exp_on || note_off !== exp_off || held !== exp_held ||
                note !== exp_note || velocity !== exp_vel || period !== 23'(exp_per)) begin
               errs++;
               $display("FAIL outputs cycle %0d: got on=%b off=%b held=%b note=%0d vel=%0d per=%0d expected on=%b off=%b held=%b note=%0d vel=%0d per=%0d",
                        cyc, note_on, note_off, held, note, velocity, period,
                        exp_on, exp_off, exp_held, exp_note, exp_vel, exp_per);
            end
         end
      end
   end

   initial begin
      int r, b;
      for (int k = 0; k < 12; k++)
         base_tab[k] = $rtoi(4800000.0 / (13.75 * (2.0 ** ((k - 9) / 12.0))) + 0.5);
      chk("base0", base_tab[0], 587099);
      chk("base9", base_tab[9], 349091);
      chk("per69", per_of(69), 10909);
      chk("per60", per_of(60), 18346);
      chk("per48", per_of(48), 36693);
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_period", int'(period), 0);
      chk("rst_held", int'(held), 0);
      // single note-on
      send(8'h90); send(8'h45); send(8'h64); step();
      chk("on_pulse", int'(note_on), 1);
      chk("on_note", int'(note), 69);
      chk("on_vel", int'(velocity), 100);
      chk("on_period", int'(period), 10909);
      chk("on_held", int'(held), 1);
      step();
      chk("on_one_cycle", int'(note_on), 0);
      // running status note-off via velocity 0
      pulse_rst();
      send(8'h90); send(8'h3C); send(8'h40); step();
      chk("rs_on_period", int'(period), 18346);
      send(8'h3C); send(8'h00); step();
      chk("rs_off_pulse", int'(note_off), 1);
      chk("rs_off_held", int'(held), 0);
      chk("rs_off_period", int'(period), 18346);
      // key mismatch note-off ignored
      pulse_rst();
      send(8'h90); send(8'h3C); send(8'h40);
      send(8'h80); send(8'h3E); send(8'h00); step();
      chk("mis_no_off", int'(note_off), 0);
      chk("mis_held", int'(held), 1);
      send(8'h80); send(8'h3C); send(8'h00); step();
      chk("match_off", int'(note_off), 1);
      // real-time bytes interleaved, then a foreign channel
      pulse_rst();
      send(8'h90); send(8'hF8); send(8'h45); send(8'hF8); send(8'h64); step();
      chk("rt_on", int'(note_on), 1);
      chk("rt_period", int'(period), 10909);
      send(8'h91); send(8'h45); send(8'h64); step();
      chk("ch1_no_on", int'(note_on), 0);
      chk("ch1_held", int'(held), 1);
      // program change ignored
      pulse_rst();
      send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h7F); step();
      chk("pc_note", int'(note), 48);
      chk("pc_period", int'(period), 36693);
      // reset mid-message
      pulse_rst();
      send(8'h90); send(8'h45); pulse_rst();
      chk("mid_rst_period", int'(period), 0);
      send(8'h64);
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_no_on", int'(note_on), 0);
         step();
      end
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) pulse_rst();
         else if (r < 14) step();
         else begin
            r = $urandom_range(0, 99);
            if (r < 12) b = 8'h90 | (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15));
            else if (r < 20) b = 8'h80 | (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15));
            else if (r < 24) b = $urandom_range(8'hA0, 8'hEF);
            else if (r < 26) b = $urandom_range(8'hF0, 8'hF7);
            else if (r < 31) b = $urandom_range(8'hF8, 8'hFF);
            else if (r < 40) b = 0;
            else if (r < 75) b = 60 + 2 * $urandom_range(0, 2);
            else b = $urandom_range(0, 127);
            send(8'(b));
         end
      end
      step();
      step();
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
